// File: rtl/cursor_controls_pkg.sv
// Shared game definitions for the battleship board.
//   GRID_SIZE    : board edge length in cells (board is GRID_SIZE x GRID_SIZE)
//   MAX_SHIP_LEN : longest ship that can be placed
//   coord_t      : 3-bit row/column index
//   mode_e       : cursor behaviour selected from the game state inputs
//   move_e       : single decoded cursor move for the current cycle
package cursor_controls_pkg;

  localparam int unsigned GRID_SIZE    = 5;
  localparam int unsigned MAX_SHIP_LEN = 5;

  typedef logic [2:0] coord_t;

  typedef enum logic [1:0] {
    ModeIdle  = 2'd0,
    ModeFire  = 2'd1,
    ModePlace = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    MoveNone  = 3'd0,
    MoveUp    = 3'd1,
    MoveDown  = 3'd2,
    MoveLeft  = 3'd3,
    MoveRight = 3'd4
  } move_e;

  // Saturate a 4-bit value at an upper limit.
  function automatic logic [3:0] sat_hi(input logic [3:0] val, input logic [3:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  // Decrement with a floor at zero.
  function automatic logic [3:0] dec_sat(input logic [3:0] val);
    return (val == 4'd0) ? 4'd0 : val - 4'd1;
  endfunction

  // Increment with a ceiling at lim.
  function automatic logic [3:0] inc_sat(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/cursor_controls_button_edge.sv
// Button conditioning for one active-low push button.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   button : raw active-low button level (asynchronous to clk)
//   press  : one-cycle pulse on each synchronized high-to-low transition
// Every register resets to 1 (released), so leaving reset never looks like a press.
module button_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= button;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Falling edge of the synchronized level; high for exactly one cycle per press.
  assign press = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cursor_controls.sv
// Cursor-movement controller for the battleship board.
//   clk, rst                    : system clock, asynchronous active-low reset
//   i_actual, j_actual          : current cursor row / column
//   colocation_ships_State      : ship-placement phase (wins over firing)
//   player_turn_State           : player-firing phase
//   player_ships_input_internal : length of the ship being placed
//   move_up/down/left/right     : active-low push buttons
//   i_next, j_next              : registered next cursor row / column
// In placement mode the ship lies horizontally on columns j..j+S-1, so the column limit
// shrinks with the ship length. In idle mode button presses are dropped.
module cursor_controls #(
  parameter int unsigned GRID_SIZE   = cursor_controls_pkg::GRID_SIZE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_actual,
  input  logic [2:0] j_actual,
  input  logic       colocation_ships_State,
  input  logic       player_turn_State,
  input  logic [2:0] player_ships_input_internal,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  output logic [2:0] i_next,
  output logic [2:0] j_next
);

  import cursor_controls_pkg::*;

  localparam logic [3:0] Grid4 = 4'(GRID_SIZE);
  localparam logic [3:0] Imax4 = 4'(GRID_SIZE - 1);

  // Button conditioning
  logic press_up, press_down, press_left, press_right;

  button_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_up (
    .clk   (clk),
    .rst   (rst),
    .button(move_up),
    .press (press_up)
  );

  button_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_down (
    .clk   (clk),
    .rst   (rst),
    .button(move_down),
    .press (press_down)
  );

  button_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_left (
    .clk   (clk),
    .rst   (rst),
    .button(move_left),
    .press (press_left)
  );

  button_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_right (
    .clk   (clk),
    .rst   (rst),
    .button(move_right),
    .press (press_right)
  );

  // Mode selection: placement has priority over firing.
  mode_e mode;

  always_comb begin
    mode = ModeIdle;
    if (colocation_ships_State) begin
      mode = ModePlace;
    end else if (player_turn_State) begin
      mode = ModeFire;
    end
  end

  // Ship length clamped to 1..GRID_SIZE.
  logic [3:0] size_raw;
  logic [3:0] ship_len;

  always_comb begin
    size_raw = {1'b0, player_ships_input_internal};
    ship_len = size_raw;
    if (size_raw == 4'd0) begin
      ship_len = 4'd1;
    end else if (size_raw > Grid4) begin
      ship_len = Grid4;
    end
  end

  // Limits and base cell, all 4 bits wide so decrements never wrap.
  logic [3:0] jmax;
  logic [3:0] i_base;
  logic [3:0] j_base;

  always_comb begin
    jmax   = (mode == ModePlace) ? (Grid4 - ship_len) : Imax4;
    i_base = sat_hi({1'b0, i_actual}, Imax4);
    j_base = sat_hi({1'b0, j_actual}, jmax);
  end

  // One move per cycle, up > down > left > right; nothing moves in idle mode.
  move_e move;

  always_comb begin
    move = MoveNone;
    if (mode != ModeIdle) begin
      if (press_up) begin
        move = MoveUp;
      end else if (press_down) begin
        move = MoveDown;
      end else if (press_left) begin
        move = MoveLeft;
      end else if (press_right) begin
        move = MoveRight;
      end
    end
  end

  logic [3:0] i_d;
  logic [3:0] j_d;

  always_comb begin
    i_d = i_base;
    j_d = j_base;
    unique case (move)
      MoveUp:    i_d = dec_sat(i_base);
      MoveDown:  i_d = inc_sat(i_base, Imax4);
      MoveLeft:  j_d = dec_sat(j_base);
      MoveRight: j_d = inc_sat(j_base, jmax);
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_next <= '0;
      j_next <= '0;
    end else begin
      i_next <= i_d[2:0];
      j_next <= j_d[2:0];
    end
  end

endmodule

// File: tb/tb_cursor_controls.sv
module tb_cursor_controls;

  localparam int G = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] ia, ja, sz;
  logic       col, pt;
  logic [3:0] btn;  // {up, down, left, right}, active-low
  logic [2:0] i_next, j_next;

  always #5 clk = ~clk;

  cursor_controls dut (
    .clk                        (clk),
    .rst                        (rst_n),
    .i_actual                   (ia),
    .j_actual                   (ja),
    .colocation_ships_State     (col),
    .player_turn_State          (pt),
    .player_ships_input_internal(sz),
    .move_up                    (btn[3]),
    .move_down                  (btn[2]),
    .move_left                  (btn[1]),
    .move_right                 (btn[0]),
    .i_next                     (i_next),
    .j_next                     (j_next)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [5:0] sb[$];
  logic [3:0] h1, h2, h3;  // button levels sampled at the last three edges
  logic [5:0] last_e;
  bit         follow;      // feed the expected cursor back as the current cell

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got i=%0d j=%0d, expected i=%0d j=%0d", tag, got[5:3], got[2:0],
               exp[5:3], exp[2:0]);
    end
  endtask

  function automatic logic [5:0] model(input int i_a, input int j_a, input bit place,
                                       input bit fire, input int size, input logic [3:0] pr);
    int s, imax, jmax, ib, jb;
    s    = (size == 0) ? 1 : ((size > G) ? G : size);
    imax = G - 1;
    jmax = place ? G - s : G - 1;
    ib   = (i_a > imax) ? imax : i_a;
    jb   = (j_a > jmax) ? jmax : j_a;
    if (place || fire) begin
      if (pr[3])      ib = (ib > 0) ? ib - 1 : 0;
      else if (pr[2]) ib = (ib < imax) ? ib + 1 : imax;
      else if (pr[1]) jb = (jb > 0) ? jb - 1 : 0;
      else if (pr[0]) jb = (jb < jmax) ? jb + 1 : jmax;
    end
    return {3'(ib), 3'(jb)};
  endfunction

  // One clock: drive at negedge, predict, then compare just after the rising edge.
  task automatic step();
    logic [5:0] e;
    logic [5:0] got;
    @(negedge clk);
    if (follow) begin
      ia = last_e[5:3];
      ja = last_e[2:0];
    end
    #1;
    if (!rst_n) e = 6'd0;
    else e = model(int'(ia), int'(ja), col, pt, int'(sz), h3 & ~h2);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      h1 = 4'hF; h2 = 4'hF; h3 = 4'hF;
    end else begin
      h3 = h2; h2 = h1; h1 = btn;
    end
    got = {i_next, j_next};
    last_e = sb.pop_front();
    check_eq("cycle", got, last_e);
  endtask

  // Press the buttons in mask for one edge, then release until the move lands.
  task automatic press(input logic [3:0] mask);
    btn = ~mask;
    step();
    btn = 4'hF;
    step();
    step();
  endtask

  task automatic set_cell(input logic [2:0] i, input logic [2:0] j);
    last_e = {i, j};
    ia = i;
    ja = j;
  endtask

  initial begin
    rst_n = 1'b0; ia = 3'd2; ja = 3'd2; sz = 3'd1; col = 1'b0; pt = 1'b0; btn = 4'hF;
    h1 = 4'hF; h2 = 4'hF; h3 = 4'hF; follow = 1'b0; last_e = 6'd0;
    step();
    check_eq("reset_init", {i_next, j_next}, 6'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("after_reset", {i_next, j_next}, {3'd2, 3'd2});

    // Mid-run asynchronous reset
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", {i_next, j_next}, 6'd0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("reset_release", {i_next, j_next}, {3'd2, 3'd2});

    // Firing mode
    pt = 1'b1; follow = 1'b1; set_cell(3'd2, 3'd2);
    press(4'b1000);
    check_eq("fire_up", {i_next, j_next}, {3'd1, 3'd2});
    set_cell(3'd2, 3'd2);
    btn = 4'b0111;
    for (int k = 0; k < 5; k++) step();
    btn = 4'hF;
    step(); step();
    check_eq("fire_hold", {i_next, j_next}, {3'd1, 3'd2});

    // Placement, S = 1
    pt = 1'b0; col = 1'b1; sz = 3'd1; set_cell(3'd2, 3'd2);
    press(4'b0001);
    check_eq("place_right", {i_next, j_next}, {3'd2, 3'd3});
    press(4'b0100);
    check_eq("place_down", {i_next, j_next}, {3'd3, 3'd3});
    set_cell(3'd2, 3'd2);
    press(4'b0010);
    check_eq("place_left", {i_next, j_next}, {3'd2, 3'd1});

    // Placement clamp, S = 3
    sz = 3'd3; set_cell(3'd2, 3'd2);
    press(4'b0001);
    check_eq("clamp_right", {i_next, j_next}, {3'd2, 3'd2});
    follow = 1'b0; ja = 3'd4;
    step();
    check_eq("clamp_base", {i_next, j_next}, {3'd2, 3'd2});
    sz = 3'd0; ja = 3'd7;  // size 0 acts as 1
    step();
    check_eq("size_zero", {i_next, j_next}, {3'd2, 3'd4});
    sz = 3'd7;             // size 7 acts as GRID_SIZE
    step();
    check_eq("size_big", {i_next, j_next}, {3'd2, 3'd0});
    pt = 1'b1; sz = 3'd2;  // both states high: placement wins
    step();
    check_eq("both_states", {i_next, j_next}, {3'd2, 3'd3});

    // Boundaries in firing mode
    col = 1'b0; follow = 1'b1; set_cell(3'd0, 3'd0);
    press(4'b1000);
    press(4'b0010);
    check_eq("corner_00", {i_next, j_next}, {3'd0, 3'd0});
    set_cell(3'd4, 3'd4);
    press(4'b0100);
    press(4'b0001);
    check_eq("corner_44", {i_next, j_next}, {3'd4, 3'd4});

    // Simultaneous presses and idle mode
    set_cell(3'd2, 3'd2);
    press(4'b1001);
    check_eq("simul", {i_next, j_next}, {3'd1, 3'd2});
    pt = 1'b0; follow = 1'b0; ia = 3'd3; ja = 3'd1;
    press(4'b1111);
    check_eq("idle", {i_next, j_next}, {3'd3, 3'd1});

    // Random traffic with feedback, checked cycle by cycle against the model
    follow = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        col = 1'($urandom_range(0, 1));
        pt  = 1'($urandom_range(0, 1));
        sz  = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) set_cell(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) btn = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cursor_controls.md
# cursor_controls

Cursor-movement controller for the battleship game board. It takes the current cursor cell (`i_actual` row, `j_actual` column) and four active-low push-button inputs, and produces the registered next cursor cell (`i_next`, `j_next`). It sits between the button inputs and the game FSM/VGA renderer. In the ship-placement phase it keeps the whole ship on the board; in the firing phase it keeps a single cell on the board. The module is implemented as `cursor_controls`.

## Interface
Parameters:
- `GRID_SIZE`, default 5: board is GRID_SIZE x GRID_SIZE; legal indices are 0..GRID_SIZE-1.
- `SYNC_STAGES`, default 2: synchronizer flip-flops per button.

Ports:
- `clk`  in  1: single system clock; all state is on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `i_actual`  in  3: current cursor row.
- `j_actual`  in  3: current cursor column.
- `colocation_ships_State`  in  1: high during the ship-placement phase.
- `player_turn_State`  in  1: high during the player-firing phase.
- `player_ships_input_internal`  in  3: length in cells of the ship being placed (1..5).
- `move_up`, `move_down`, `move_left`, `move_right`  in  1 each: active-low buttons (0 = pressed).
- `i_next`  out  3: registered next row.
- `j_next`  out  3: registered next column.

## Operation
- **Button conditioning.** Each button passes through a SYNC_STAGES synchronizer, then a falling-edge detector. One press produces exactly one move, however long the button is held.
- **Ship size.** `S` = `player_ships_input_internal`, clamped to 1..GRID_SIZE (0 is treated as 1; values above GRID_SIZE are treated as GRID_SIZE).
- **Mode selection** (priority order):
  - `colocation_ships_State` = 1: placement mode. This mode wins if both state inputs are high.
  - otherwise `player_turn_State` = 1: firing mode.
  - otherwise: idle mode.
- **Limits.**
  - Row limit is always `IMAX` = GRID_SIZE-1.
  - Column limit `JMAX` is GRID_SIZE-S in placement mode (ship is horizontal, occupying columns j..j+S-1) and GRID_SIZE-1 otherwise.
- **Base cell.** `i_b` = min(`i_actual`, IMAX); `j_b` = min(`j_actual`, JMAX).
- **Moves.** At most one move per cycle, priority up > down > left > right for simultaneous edge pulses.
  - up: i_b-1, saturating at 0.
  - down: i_b+1, saturating at IMAX.
  - left: j_b-1, saturating at 0.
  - right: j_b+1, saturating at JMAX.
  - There is no wrap-around.
- **Idle mode.** Edge pulses are ignored and the outputs track the clamped base cell.
- **Every cycle:** `i_next`/`j_next` are loaded with the result, or with the base cell when there is no move.
- **Arithmetic.** Performed 4 bits wide to avoid underflow, then truncated to 3 bits.

## Timing
- **Reset.** While `rst` = 0: `i_next` = 0, `j_next` = 0, and all synchronizer and edge registers hold 1 (released level). Reset takes effect immediately and is asynchronous. Releasing reset never produces a spurious edge.
- **Move latency.** A button falling before rising edge k updates the outputs at edge k+SYNC_STAGES, which is edge k+2 by default. A press must be held low across at least one rising edge to be seen.
- **Other inputs.** Changes to `i_actual`, `j_actual`, the state inputs or the size appear at the outputs after one edge.
- **Mode change during a pending edge pulse.** The mode in effect on the cycle the pulse is consumed governs the move.

## Structure
- Shared game package holds `GRID_SIZE`, `MAX_SHIP_LEN` = 5, and the 3-bit `coord_t` typedef.
- Sub-module `button_edge`: synchronizer plus falling-edge detector, one instance per button. It produces a one-cycle `press` pulse.
- The top level holds mode/limit logic and the output registers.

## Test plan
- **Reset.** Assert `rst` = 0 mid-run with `i_actual` = 2, `j_actual` = 2 -> outputs go to 0,0 immediately. Release -> outputs become 2,2 after one edge, with no move.
- **Firing move.** `player_turn_State` = 1, hold `move_up` low for one cycle from 2,2 -> `i_next` = 1, `j_next` = 2 after 2 edges. Holding the button longer -> still exactly one move.
- **Placement move, S = 1.** From 2,2, press right -> `j_next` = 3. Press down -> `i_next` = 3. Press left -> `j_next` = 1.
- **Placement clamp, S = 3.** Columns 0..2 are legal. `j_actual` = 2, press right -> `j_next` stays 2. Set `j_actual` = 4 with no press -> `j_next` = 2.
- **Boundaries.** Firing at 0,0, press up and left -> stays 0,0. At 4,4, press down and right -> stays 4,4.
- **Simultaneous and idle.** Up and right pressed on the same cycle in firing mode from 2,2 -> 1,2. Both state inputs low, presses applied -> outputs stay equal to the inputs.
